// File: rtl/pma_serializer.sv
// rtl/pma_serializer.sv - PMA transmit parallel-to-serial converter
//
// Accepts WIDTH-bit code-groups from the PCS into a one-word holding
// register and emits them back-to-back as a gapless serial bitstream,
// one bit per clock, flagging word boundaries and stream underruns.
//
// Parameters:
//   WIDTH     code-group width in bits (>= 2)
//   IDLE_BIT  level on ser_out while no word is being shifted
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   par_data    parallel code-group from the PCS
//   par_valid   par_data is valid
//   par_ready   holding register empty; accept on par_valid && par_ready
//   ser_out     serial bitstream
//   ser_valid   ser_out carries a data bit
//   word_start  ser_out carries the first bit of a word
//   underrun    one-cycle pulse: stream ended with no next word staged
//
// Build option:
//   SER_LSB_FIRST_EN  defined: LSB-first transmission; undefined: MSB-first
module pma_serializer #(
  parameter int   WIDTH    = 10,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_start,
  output logic             underrun
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic [CW-1:0]    bit_cnt_q,   bit_cnt_d;
  logic             busy_q,      busy_d;
  logic             underrun_q,  underrun_d;

  logic             last_bit;

  // Last bit of the current word is on the line this cycle.
  assign last_bit = busy_q && (bit_cnt_q == LAST);

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    busy_d      = busy_q;
    underrun_d  = 1'b0;

    // Accept can never coincide with load: it needs the hold register
    // empty, while load needs it full.
    if (par_valid && !hold_full_q) begin
      hold_d      = par_data;
      hold_full_d = 1'b1;
    end

    if ((!busy_q || last_bit) && hold_full_q) begin
      // Load the staged word; when it follows a last bit the stream is gapless.
      shreg_d     = hold_q;
      bit_cnt_d   = '0;
      busy_d      = 1'b1;
      hold_full_d = 1'b0;
    end else if (last_bit) begin
      // Word finished with nothing staged: stream ends.
      busy_d      = 1'b0;
      bit_cnt_d   = '0;
      shreg_d     = {WIDTH{IDLE_BIT}};
      underrun_d  = 1'b1;
    end else if (busy_q) begin
`ifdef SER_LSB_FIRST_EN
      shreg_d   = {IDLE_BIT, shreg_q[WIDTH-1:1]};
`else
      shreg_d   = {shreg_q[WIDTH-2:0], IDLE_BIT};
`endif
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= {WIDTH{IDLE_BIT}};
      bit_cnt_q   <= '0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign par_ready  = !hold_full_q;
  assign ser_valid  = busy_q;
  assign word_start = busy_q && (bit_cnt_q == '0);
  assign underrun   = underrun_q;
`ifdef SER_LSB_FIRST_EN
  assign ser_out    = shreg_q[0];
`else
  assign ser_out    = shreg_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_pma_serializer.sv
// tb/tb_pma_serializer.sv - directed self-checking bench for pma_serializer
module tb_pma_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] par_data;
  logic       par_valid;
  logic       par_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       word_start;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  pma_serializer #(.WIDTH(10), .IDLE_BIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .par_data   (par_data),
    .par_valid  (par_valid),
    .par_ready  (par_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .word_start (word_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial order of a word as it should appear on the line, first bit in [9].
  function automatic logic [9:0] line_order(input logic [9:0] w);
    logic [9:0] r;
`ifdef SER_LSB_FIRST_EN
    for (int i = 0; i < 10; i++) r[9-i] = w[i];
`else
    r = w;
`endif
    return r;
  endfunction

  initial begin
    logic [9:0]  single_seq;
    logic [9:0]  words [3];
    logic [29:0] exp_stream;
    logic [29:0] got_stream;
    int          k;
    int          nbits;
    int          first_v;
    int          last_v;
    int          ready_low;
    int          early_ur;
    int          ur_tick;
    int          acc_tick [3];
    logic        acc;
    logic        seen_v;
    logic        seen_ur;

    // Hand-derived line order for 10'b1100000101.
`ifdef SER_LSB_FIRST_EN
    single_seq = 10'b1010000011;
`else
    single_seq = 10'b1100000101;
`endif

    // ---------------- reset ----------------
    reset     = 1'b1;
    par_valid = 1'b1;
    par_data  = 10'h3FF;
    tick(); tick(); tick();
    chk("rst_par_ready", par_ready, 1);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_word_start", word_start, 0);
    reset     = 1'b0;
    par_valid = 1'b0;
    tick();
    chk("rst_nothing_accepted_ready", par_ready, 1);
    chk("rst_nothing_accepted_valid", ser_valid, 0);

    // ---------------- single word ----------------
    par_data  = 10'b1100000101;
    par_valid = 1'b1;
    tick();                                     // edge T: accept
    par_valid = 1'b0;
    chk("single_ready_after_accept", par_ready, 0);
    chk("single_no_output_yet", ser_valid, 0);
    for (int i = 0; i < 10; i++) begin
      tick();                                   // edges T+1 .. T+10
      chk($sformatf("single_bit%0d", i), ser_out, single_seq[9-i]);
      chk($sformatf("single_valid%0d", i), ser_valid, 1);
      chk($sformatf("single_ws%0d", i), word_start, (i == 0) ? 1 : 0);
      chk($sformatf("single_ur%0d", i), underrun, 0);
    end
    tick();                                     // edge T+11
    chk("single_underrun_pulse", underrun, 1);
    chk("single_end_valid", ser_valid, 0);
    chk("single_end_out", ser_out, 0);
    tick();
    chk("single_underrun_one_cycle", underrun, 0);
    chk("single_idle_out", ser_out, 0);

    // ---------------- streaming + backpressure ----------------
    words[0]   = 10'h305;
    words[1]   = 10'h0FA;
    words[2]   = 10'h2AA;
    exp_stream = {line_order(words[0]), line_order(words[1]), line_order(words[2])};
    got_stream = '0;
    k = 0; nbits = 0; first_v = -1; last_v = -1;
    ready_low = 0; early_ur = 0; ur_tick = -1;
    acc_tick[0] = -1; acc_tick[1] = -1; acc_tick[2] = -1;
    par_data  = words[0];
    par_valid = 1'b1;
    for (int t = 1; t <= 34; t++) begin
      acc = par_valid && par_ready;
      tick();
      if (acc) begin
        acc_tick[k] = t;
        k++;
        if (k == 3) par_valid = 1'b0;
        else        par_data  = words[k];
      end
      if (!par_ready) ready_low++;
      if (ser_valid) begin
        if (first_v < 0) first_v = t;
        last_v = t;
        if (nbits < 30) got_stream[29-nbits] = ser_out;
        nbits++;
      end
      if (underrun) begin
        if (nbits < 30) early_ur++;
        else if (ur_tick < 0) ur_tick = t;
      end
    end
    chk("stream_accept_w0", acc_tick[0], 1);
    chk("stream_accept_w1", acc_tick[1], 3);
    chk("stream_accept_w2", acc_tick[2], 13);
    chk("stream_ready_low_cycles", ready_low, 19);
    chk("stream_bit_count", nbits, 30);
    chk("stream_first_valid", first_v, 2);
    chk("stream_last_valid", last_v, 31);
    chk("stream_data", got_stream, exp_stream);
    chk("stream_no_early_underrun", early_ur, 0);
    chk("stream_underrun_tick", ur_tick, 32);

    // ---------------- reset mid-word ----------------
    par_data  = 10'h305;
    par_valid = 1'b1;
    tick();                                     // accept 0x305
    par_data  = 10'h0FA;
    tick();                                     // load 0x305, bit 1
    chk("mid_first_bit", ser_out, line_order(10'h305) >> 9);
    chk("mid_ready_before_stage", par_ready, 1);
    tick();                                     // accept 0x0FA, bit 2
    par_valid = 1'b0;
    chk("mid_staged", par_ready, 0);
    tick();                                     // bit 3
    tick();                                     // bit 4
    chk("mid_fourth_bit_valid", ser_valid, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", ser_valid, 0);
    chk("mid_rst_out", ser_out, 0);
    chk("mid_rst_ready", par_ready, 1);
    chk("mid_rst_underrun", underrun, 0);
    reset   = 1'b0;
    seen_v  = 1'b0;
    seen_ur = 1'b0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (ser_valid) seen_v = 1'b1;
      if (underrun)  seen_ur = 1'b1;
    end
    chk("mid_staged_word_discarded", seen_v, 0);
    chk("mid_no_underrun", seen_ur, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
